demux_1to4: RTL and testbench

Registered 1-to-N demultiplexer (default 1:4). It routes a single input word to one of N output lanes selected by a binary select, and drives all other lanes to zero. Used as a generic steering element wherever one source must fan out to one of several sinks. Outputs are registered on one clock with an asynchronous active-high reset.

---
 rtl/demux_pkg.sv | 22 ++
 rtl/demux_dec.sv | 22 ++
 rtl/demux_1to4.sv | 51 +++++
 tb/tb_demux_1to4.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// Shared constants and the binary-to-one-hot helper for the demux family.
// onehot_dec works on a fixed maximum width; callers narrow the result to N_OUT bits.
package demux_pkg;

  localparam int DEMUX_DATA_W  = 1;
  localparam int DEMUX_N_OUT   = 4;
  localparam int DEMUX_MAX_OUT = 32;

  // Bit k is set when sel == k and k < n; all zeros when sel >= n.
  function automatic logic [DEMUX_MAX_OUT-1:0] onehot_dec(
    input logic [DEMUX_MAX_OUT-1:0] sel,
    input int                       n
  );
    logic [DEMUX_MAX_OUT-1:0] v;
    v = '0;
    for (int k = 0; k < DEMUX_MAX_OUT; k++) begin
      if (k < n && sel == DEMUX_MAX_OUT'(k)) v[k] = 1'b1;
    end
    return v;
  endfunction

endpackage

// File: rtl/demux_dec.sv
// Combinational binary-to-one-hot decoder with range check.
// An index with no matching lane shows up as an all-zero vector and oor=1.
module demux_dec
  import demux_pkg::*;
#(
  parameter  int N_OUT = DEMUX_N_OUT,
  localparam int SEL_W = $clog2(N_OUT)
) (
  input  logic [SEL_W-1:0] sel,
  output logic [N_OUT-1:0] onehot,
  output logic             oor
);

  always_comb begin
    // NOTE: every output gets a default first so no path through the block infers a latch.
    onehot = '0;
    oor    = 1'b0;
    onehot = N_OUT'(onehot_dec(DEMUX_MAX_OUT'(sel), N_OUT));
    oor    = ~|onehot;
  end

endmodule

// File: rtl/demux_1to4.sv
// Registered 1-to-N demultiplexer: din is steered to lane[sel], all other lanes are zero.
// dout_sel marks the selected lane so a selected zero can be told apart from no selection.
module demux_1to4
  import demux_pkg::*;
#(
  parameter  int DATA_W = DEMUX_DATA_W,
  parameter  int N_OUT  = DEMUX_N_OUT,
  localparam int SEL_W  = $clog2(N_OUT)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [DATA_W-1:0]       din,
  input  logic [SEL_W-1:0]        sel,
  output logic [N_OUT*DATA_W-1:0] dout,
  output logic [N_OUT-1:0]        dout_sel,
  output logic                    sel_err
);

  logic [N_OUT-1:0]        dec_onehot;
  logic                    dec_oor;
  logic [N_OUT*DATA_W-1:0] lanes_d;

  demux_dec #(.N_OUT(N_OUT)) u_dec (
    .sel    (sel),
    .onehot (dec_onehot),
    .oor    (dec_oor)
  );

  // Each lane is din gated by its decode bit, so at most one lane can be non-zero.
  always_comb begin
    lanes_d = '0;
    for (int k = 0; k < N_OUT; k++) begin
      lanes_d[k*DATA_W +: DATA_W] = din & {DATA_W{dec_onehot[k] & en}};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: non-blocking so every register samples pre-edge values, independent of statement order.
      dout     <= '0;
      dout_sel <= '0;
      sel_err  <= 1'b0;
    end else begin
      dout     <= lanes_d;
      dout_sel <= en ? dec_onehot : '0;
      sel_err  <= en & dec_oor;
    end
  end

endmodule

// File: tb/tb_demux_1to4.sv
// Self-checking bench for demux_1to4: a default 1x4 build and a wide 8-bit x 3-lane build,
// both compared every cycle against an arithmetic reference with one cycle of delay.
module tb_demux_1to4;

  logic        clk;
  logic        rst;

  logic        en4;
  logic [1:0]  sel4;
  logic        din4;
  logic [3:0]  dout4;
  logic [3:0]  dout_sel4;
  logic        sel_err4;

  logic        en3;
  logic [1:0]  sel3;
  logic [7:0]  din3;
  logic [23:0] dout3;
  logic [2:0]  dout_sel3;
  logic        sel_err3;

  int checks   = 0;
  int failures = 0;

  // Expected outputs now, and the values the next edge will produce.
  logic [3:0]  e4_dout, e4_sel, p4_dout, p4_sel;
  logic        e4_err, p4_err;
  logic [23:0] e3_dout, p3_dout;
  logic [2:0]  e3_sel, p3_sel;
  logic        e3_err, p3_err;

  demux_1to4 dut4 (
    .clk      (clk),
    .rst      (rst),
    .en       (en4),
    .din      (din4),
    .sel      (sel4),
    .dout     (dout4),
    .dout_sel (dout_sel4),
    .sel_err  (sel_err4)
  );

  demux_1to4 #(.DATA_W(8), .N_OUT(3)) dut3 (
    .clk      (clk),
    .rst      (rst),
    .en       (en3),
    .din      (din3),
    .sel      (sel3),
    .dout     (dout3),
    .dout_sel (dout_sel3),
    .sel_err  (sel_err3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Unknown select while enabled is illegal stimulus.
  always @(posedge clk) begin
    if (!rst) begin
      assert (!(en4 && $isunknown(sel4)) && !(en3 && $isunknown(sel3))) else begin
        failures++;
        $error("FAIL sel_unknown observed=%b/%b required=known", sel4, sel3);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string where);
    check({where, ".dout4"},     32'(dout4),              32'(e4_dout));
    check({where, ".dout_sel4"}, 32'(dout_sel4),          32'(e4_sel));
    check({where, ".sel_err4"},  32'(sel_err4),           32'(e4_err));
    check({where, ".lanes4"},    32'($countones(dout4) <= 1), 32'd1);
    check({where, ".dout3"},     32'(dout3),              32'(e3_dout));
    check({where, ".dout_sel3"}, 32'(dout_sel3),          32'(e3_sel));
    check({where, ".sel_err3"},  32'(sel_err3),           32'(e3_err));
  endtask

  task automatic drive4(input logic e, input int s, input logic d);
    en4  = e;
    sel4 = 2'(s);
    din4 = d;
    p4_dout = (e && s < 4) ? (4'(d) << s) : 4'd0;
    p4_sel  = (e && s < 4) ? (4'd1 << s)  : 4'd0;
    p4_err  = e && s >= 4;
  endtask

  task automatic drive3(input logic e, input int s, input logic [7:0] d);
    en3  = e;
    sel3 = 2'(s);
    din3 = d;
    p3_dout = (e && s < 3) ? (24'(d) << (8 * s)) : 24'd0;
    p3_sel  = (e && s < 3) ? (3'd1 << s)         : 3'd0;
    p3_err  = e && s >= 3;
  endtask

  task automatic clear_expected();
    e4_dout = '0; e4_sel = '0; e4_err = 1'b0;
    e3_dout = '0; e3_sel = '0; e3_err = 1'b0;
  endtask

  task automatic tick(input string where);
    @(posedge clk);
    e4_dout = p4_dout; e4_sel = p4_sel; e4_err = p4_err;
    e3_dout = p3_dout; e3_sel = p3_sel; e3_err = p3_err;
    #1;
    check_all(where);
  endtask

  // Mid-cycle reset pulse: outputs must clear with no clock edge.
  task automatic reset_pulse(input string where);
    #2 rst = 1'b1;
    clear_expected();
    #1 check_all(where);
    #1 rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    drive4(1'b0, 0, 1'b0);
    drive3(1'b0, 0, 8'h00);
    clear_expected();
    repeat (2) @(posedge clk);
    #1 check_all("reset");
    #3 rst = 1'b0;

    for (int s = 0; s < 4; s++) begin
      drive4(1'b1, s, 1'b0);
      tick("zero_sweep");
    end

    for (int s = 0; s < 4; s++) begin
      drive4(1'b1, s, 1'b1);
      tick("one_sweep");
    end

    drive4(1'b1, 3, 1'b1); tick("en_on");
    drive4(1'b0, 3, 1'b1); tick("en_off");
    drive4(1'b1, 3, 1'b1); tick("en_back");

    drive4(1'b1, 2, 1'b1);
    tick("pre_reset");
    reset_pulse("async_reset");
    tick("after_reset");

    drive3(1'b1, 1, 8'hA5); tick("wide_sel1");
    drive3(1'b1, 3, 8'hA5); tick("wide_oor");
    drive3(1'b1, 0, 8'h3C); tick("wide_err_drop");
    drive3(1'b1, 2, 8'h00); tick("wide_zero");

    for (int i = 0; i < 1000; i++) begin
      tick("random");
      if ($urandom_range(49) == 0) reset_pulse("random_reset");
      drive4(($urandom_range(7) != 0), int'($urandom_range(3)), 1'($urandom));
      drive3(($urandom_range(7) != 0), int'($urandom_range(3)), 8'($urandom));
      #2 check_all("no_comb_path");
    end
    tick("random_last");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
